// File: rtl/concat_pack_stream.sv
// rtl/concat_pack_stream.sv - narrow-to-wide stream packer with early flush and single-word bypass
// First accepted word lands in the most significant lane; one output holding stage.
module concat_pack_stream #(
   parameter  int IN_W  = 8,
   parameter  int BEATS = 2,
   localparam int OUT_W = IN_W * BEATS,
   localparam int CNT_W = $clog2(BEATS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_last,
   input  logic             in_bypass,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_bypass
);

   typedef enum logic {FILL, SEND} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OUT_W-1:0] acc_q, acc_d;
   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;
   logic             out_bypass_q, out_bypass_d;
   logic [OUT_W-1:0] lane_word;

   // A bypass word must not be merged into a partial word, so it stalls until the partial drains.
   assign in_ready = (state_q == FILL) && !(in_bypass && (cnt_q != '0));

   always_comb begin
      lane_word    = OUT_W'(in_data) << (IN_W * (BEATS - 1 - int'(cnt_q)));
      state_d      = state_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_count_d  = out_count_q;
      out_bypass_d = out_bypass_q;
      case (state_q)
         FILL: begin
            if (in_valid && in_bypass) begin
               if (cnt_q == '0) begin
                  out_data_d   = OUT_W'(in_data);
                  out_count_d  = CNT_W'(1);
                  out_bypass_d = 1'b1;
               end else begin
                  out_data_d   = acc_q;
                  out_count_d  = cnt_q;
                  out_bypass_d = 1'b0;
                  acc_d        = '0;
                  cnt_d        = '0;
               end
               out_valid_d = 1'b1;
               state_d     = SEND;
            end else if (in_valid) begin
               if ((cnt_q == CNT_W'(BEATS - 1)) || in_last) begin
                  out_data_d   = acc_q | lane_word;
                  out_count_d  = cnt_q + 1'b1;
                  out_bypass_d = 1'b0;
                  out_valid_d  = 1'b1;
                  acc_d        = '0;
                  cnt_d        = '0;
                  state_d      = SEND;
               end else begin
                  acc_d = acc_q | lane_word;
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         SEND: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = FILL;
            end
         end
         default: begin
            state_d     = FILL;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= FILL;
         cnt_q        <= '0;
         acc_q        <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_count_q  <= '0;
         out_bypass_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_count_q  <= out_count_d;
         out_bypass_q <= out_bypass_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_count  = out_count_q;
   assign out_bypass = out_bypass_q;

endmodule

// File: tb/tb_concat_pack_stream.sv
// tb/tb_concat_pack_stream.sv - directed vector bench for concat_pack_stream (BEATS=2 and BEATS=4)
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_concat_pack_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst2_n, v2, rdy2, last2, byp2, ov2, ordy2, obyp2;
   logic [7:0]  d2;
   logic [15:0] od2;
   logic [1:0]  ocnt2;

   logic        rst4_n, v4, rdy4, last4, byp4, ov4, ordy4, obyp4;
   logic [7:0]  d4;
   logic [31:0] od4;
   logic [2:0]  ocnt4;

   concat_pack_stream #(.IN_W(8), .BEATS(2)) u_dut2 (
      .clk(clk), .rst_n(rst2_n), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
      .in_last(last2), .in_bypass(byp2), .out_valid(ov2), .out_ready(ordy2),
      .out_data(od2), .out_count(ocnt2), .out_bypass(obyp2));

   concat_pack_stream #(.IN_W(8), .BEATS(4)) u_dut4 (
      .clk(clk), .rst_n(rst4_n), .in_valid(v4), .in_ready(rdy4), .in_data(d4),
      .in_last(last4), .in_bypass(byp4), .out_valid(ov4), .out_ready(ordy4),
      .out_data(od4), .out_count(ocnt4), .out_bypass(obyp4));

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        last;
      logic        byp;
      logic        ordy;
      logic        e_rdy;
      logic        e_ov;
      logic [15:0] e_data;
      logic [1:0]  e_cnt;
      logic        e_byp;
   } vec_t;

   vec_t tbl[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [7:0] d, input logic last, input logic byp,
                      input logic ordy, input logic e_rdy, input logic e_ov,
                      input logic [15:0] e_data, input logic [1:0] e_cnt, input logic e_byp);
      vec_t r;
      r.v = v; r.d = d; r.last = last; r.byp = byp; r.ordy = ordy;
      r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_data = e_data; r.e_cnt = e_cnt; r.e_byp = e_byp;
      tbl.push_back(r);
   endtask

   task automatic step4(input logic v, input logic [7:0] d);
      @(negedge clk);
      v4 = v;
      d4 = d;
   endtask

   initial begin
      rst2_n = 1'b0; v2 = 0; d2 = 0; last2 = 0; byp2 = 0; ordy2 = 1;
      rst4_n = 1'b0; v4 = 0; d4 = 0; last4 = 0; byp4 = 0; ordy4 = 1;

      // Each row: inputs for this cycle, expected in_ready and the registered outputs visible in it.
      //   v  data   last byp ordy | rdy ov  data     cnt byp
      add(0, 8'h00, 0, 0, 1,   1, 0, 16'h0000, 0, 0);
      add(1, 8'hA5, 0, 0, 1,   1, 0, 16'h0000, 0, 0);
      add(1, 8'h3C, 0, 0, 1,   1, 0, 16'h0000, 0, 0);
      add(0, 8'h00, 0, 0, 1,   0, 1, 16'hA53C, 2, 0);
      add(1, 8'h77, 1, 0, 1,   1, 0, 16'h0000, 0, 0);
      add(0, 8'h00, 0, 0, 1,   0, 1, 16'h7700, 1, 0);
      add(1, 8'h12, 0, 0, 1,   1, 0, 16'h0000, 0, 0);
      add(1, 8'h34, 0, 0, 1,   1, 0, 16'h0000, 0, 0);
      add(0, 8'h00, 0, 0, 1,   0, 1, 16'h1234, 2, 0);
      add(1, 8'h5A, 0, 1, 1,   1, 0, 16'h0000, 0, 0);
      add(0, 8'h00, 0, 0, 1,   0, 1, 16'h005A, 1, 1);
      add(1, 8'h11, 0, 0, 1,   1, 0, 16'h0000, 0, 0);
      add(1, 8'h22, 0, 1, 1,   0, 0, 16'h0000, 0, 0);
      add(1, 8'h22, 0, 1, 1,   0, 1, 16'h1100, 1, 0);
      add(1, 8'h22, 0, 1, 1,   1, 0, 16'h0000, 0, 0);
      add(0, 8'h00, 0, 0, 1,   0, 1, 16'h0022, 1, 1);
      add(1, 8'hDE, 0, 0, 1,   1, 0, 16'h0000, 0, 0);
      add(1, 8'hAD, 0, 0, 0,   1, 0, 16'h0000, 0, 0);
      add(0, 8'h00, 0, 0, 0,   0, 1, 16'hDEAD, 2, 0);
      add(1, 8'hFF, 0, 0, 0,   0, 1, 16'hDEAD, 2, 0);
      add(0, 8'h00, 0, 0, 0,   0, 1, 16'hDEAD, 2, 0);
      add(0, 8'h00, 0, 0, 1,   0, 1, 16'hDEAD, 2, 0);
      add(0, 8'h00, 0, 0, 1,   1, 0, 16'h0000, 0, 0);

      @(negedge clk);
      #1;
      chk("rst2_out_valid", 32'(ov2), 32'd0);
      chk("rst2_out_data", 32'(od2), 32'd0);
      chk("rst2_out_count", 32'(ocnt2), 32'd0);
      chk("rst2_out_bypass", 32'(obyp2), 32'd0);
      rst2_n = 1'b1;

      foreach (tbl[i]) begin
         @(negedge clk);
         v2 = tbl[i].v; d2 = tbl[i].d; last2 = tbl[i].last; byp2 = tbl[i].byp; ordy2 = tbl[i].ordy;
         #1;
         chk($sformatf("row%0d_in_ready", i), 32'(rdy2), 32'(tbl[i].e_rdy));
         chk($sformatf("row%0d_out_valid", i), 32'(ov2), 32'(tbl[i].e_ov));
         if (tbl[i].e_ov) begin
            chk($sformatf("row%0d_out_data", i), 32'(od2), 32'(tbl[i].e_data));
            chk($sformatf("row%0d_out_count", i), 32'(ocnt2), 32'(tbl[i].e_cnt));
            chk($sformatf("row%0d_out_bypass", i), 32'(obyp2), 32'(tbl[i].e_byp));
         end
      end
      @(negedge clk);
      v2 = 0;

      // BEATS=4: reset during SEND, then reset during a partial fill, then a full word.
      rst4_n = 1'b1;
      ordy4  = 1'b0;
      step4(1, 8'h01); step4(1, 8'h02); step4(1, 8'h03); step4(1, 8'h04);
      step4(0, 8'h00);
      #1;
      chk("b4_held_valid", 32'(ov4), 32'd1);
      chk("b4_held_data", od4, 32'h01020304);
      #2;
      rst4_n = 1'b0;
      #1;
      chk("b4_rst_send_valid", 32'(ov4), 32'd0);
      chk("b4_rst_send_data", od4, 32'd0);
      chk("b4_rst_send_count", 32'(ocnt4), 32'd0);
      @(negedge clk);
      rst4_n = 1'b1;
      ordy4  = 1'b1;
      step4(1, 8'h01); step4(1, 8'h02);
      step4(0, 8'h00);
      rst4_n = 1'b0;
      #1;
      chk("b4_rst_part_valid", 32'(ov4), 32'd0);
      chk("b4_rst_part_data", od4, 32'd0);
      chk("b4_rst_part_count", 32'(ocnt4), 32'd0);
      chk("b4_rst_part_bypass", 32'(obyp4), 32'd0);
      @(negedge clk);
      rst4_n = 1'b1;
      step4(1, 8'hAA); step4(1, 8'hBB); step4(1, 8'hCC);
      step4(1, 8'hDD);
      #1;
      chk("b4_before_done_valid", 32'(ov4), 32'd0);
      step4(0, 8'h00);
      #1;
      chk("b4_valid", 32'(ov4), 32'd1);
      chk("b4_data", od4, 32'hAABBCCDD);
      chk("b4_count", 32'(ocnt4), 32'd4);
      chk("b4_bypass", 32'(obyp4), 32'd0);
      chk("b4_ready_in_send", 32'(rdy4), 32'd0);
      step4(0, 8'h00);
      #1;
      chk("b4_drained", 32'(ov4), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
